// File: rtl/alu_issue_pkg.sv
// Shared ALU op codes, request kinds, FSM state encodings and branch-sense codes.
package alu_issue_pkg;

  // ALU op codes shared with the ALU itself.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Request kind codes carried on in_kind.
  localparam logic [1:0] KIND_R   = 2'b00;
  localparam logic [1:0] KIND_I   = 2'b01;
  localparam logic [1:0] KIND_BR  = 2'b10;
  localparam logic [1:0] KIND_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // How the branch outcome is derived from the ALU result/flags.
  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,  // not a branch, taken is 0
    BR_ZERO  = 3'd1,  // taken = zero flag
    BR_NZERO = 3'd2,  // taken = !zero flag
    BR_RES0  = 3'd3,  // taken = res[0]
    BR_NRES0 = 3'd4   // taken = !res[0]
  } br_sense_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of kind/funct3/funct7b5 into ALU op, branch sense and error.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [1:0] i_kind,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output alu_op_e    o_op,
  output br_sense_e  o_sense,
  output logic       o_err
);

  logic w_is_r;
  assign w_is_r = (i_kind == KIND_R);

  // Decode table; b5 only qualifies SUB/SRA, elsewhere it is illegal for
  // R-type and (except for SLLI) part of the immediate for I-type.
  always_comb begin
    o_op    = ALU_ADD;
    o_sense = BR_NONE;
    o_err   = 1'b0;
    case (i_kind)
      KIND_R, KIND_I: begin
        case (i_funct3)
          3'b000: o_op = (w_is_r && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: begin o_op = ALU_SLL;  o_err = i_funct7b5;           end
          3'b010: begin o_op = ALU_SLT;  o_err = w_is_r && i_funct7b5; end
          3'b011: begin o_op = ALU_SLTU; o_err = w_is_r && i_funct7b5; end
          3'b100: begin o_op = ALU_XOR;  o_err = w_is_r && i_funct7b5; end
          3'b101: o_op = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: begin o_op = ALU_OR;   o_err = w_is_r && i_funct7b5; end
          default: begin o_op = ALU_AND; o_err = w_is_r && i_funct7b5; end
        endcase
      end
      KIND_BR: begin
        case (i_funct3)
          3'b000: begin o_op = ALU_SUB;  o_sense = BR_ZERO;  end
          3'b001: begin o_op = ALU_SUB;  o_sense = BR_NZERO; end
          3'b100: begin o_op = ALU_SLT;  o_sense = BR_RES0;  end
          3'b101: begin o_op = ALU_SLT;  o_sense = BR_NRES0; end
          3'b110: begin o_op = ALU_SLTU; o_sense = BR_RES0;  end
          3'b111: begin o_op = ALU_SLTU; o_sense = BR_NRES0; end
          default: o_err = 1'b1;
        endcase
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts a decoded request, drives the ALU, captures the
// result on the following posedge and holds it on a backpressured output.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | ALU operands stable, ALU evaluates on the negedge
// HOLD  | result valid, waiting for out_ready
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter bit SHAMT_MASK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic [31:0] alu_lhs,
  output logic [31:0] alu_rhs,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic [3:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        out_taken,
  output logic        out_err
);

  state_e    r_state, w_state_nxt;
  logic      [31:0] r_alu_lhs, r_alu_rhs, r_out_res;
  alu_op_e   r_alu_op;
  br_sense_e r_sense;
  logic      r_err, r_out_taken, r_out_err;

  alu_op_e   w_op;
  br_sense_e w_sense;
  logic      w_err;
  logic      [31:0] w_rhs;
  logic      w_taken;
  logic      w_accept_in;
  logic      w_unused_flags;

  alu_issue_decode u_decode (
    .i_kind     (in_kind),
    .i_funct3   (in_funct3),
    .i_funct7b5 (in_funct7b5),
    .o_op       (w_op),
    .o_sense    (w_sense),
    .o_err      (w_err)
  );

  assign w_accept_in    = (r_state == ST_IDLE) && in_valid;
  assign w_unused_flags = ^alu_flags[2:0];

  // Shift amount masking keeps the upper rhs bits out of the ALU shifter.
  always_comb begin
    w_rhs = in_rs2;
    if (SHAMT_MASK && is_shift(w_op) && !w_err)
      w_rhs = {27'd0, in_rs2[4:0]};
  end

  // Branch outcome from the captured-this-edge ALU result and zero flag.
  always_comb begin
    w_taken = 1'b0;
    case (r_sense)
      BR_ZERO:  w_taken = alu_flags[3];
      BR_NZERO: w_taken = !alu_flags[3];
      BR_RES0:  w_taken = alu_res[0];
      BR_NRES0: w_taken = !alu_res[0];
      default:  w_taken = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand/op registration on accept and result capture on EXEC exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_lhs   <= 32'd0;
      r_alu_rhs   <= 32'd0;
      r_alu_op    <= ALU_ADD;
      r_sense     <= BR_NONE;
      r_err       <= 1'b0;
      r_out_res   <= 32'd0;
      r_out_taken <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_accept_in) begin
        r_alu_lhs <= in_rs1;
        r_alu_rhs <= w_rhs;
        r_sense   <= w_err ? BR_NONE : w_sense;
        r_err     <= w_err;
        // An illegal request leaves the ALU op untouched.
        if (!w_err) r_alu_op <= w_op;
      end
      if (r_state == ST_EXEC) begin
        r_out_res   <= r_err ? 32'd0 : alu_res;
        r_out_taken <= r_err ? 1'b0 : w_taken;
        r_out_err   <= r_err;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_HOLD);
  assign alu_lhs   = r_alu_lhs;
  assign alu_rhs   = r_alu_rhs;
  assign alu_op    = r_alu_op;
  assign out_res   = r_out_res;
  assign out_taken = r_out_taken;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU evaluating on negedge.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1, in_rs2;
  logic [31:0] alu_lhs, alu_rhs;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;
  logic [3:0]  alu_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic        out_taken, out_err;

  int n_cmp = 0;
  int n_mis = 0;

  alu_issue #(.SHAMT_MASK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_op(alu_op),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_taken(out_taken), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: evaluates on the negedge from the registered operands.
  always @(negedge clk) begin
    logic [32:0] t;
    logic [31:0] r;
    t = 33'd0;
    case (alu_op)
      4'd0: begin t = {1'b0, alu_lhs} + {1'b0, alu_rhs}; r = t[31:0]; end
      4'd1: begin t = {1'b0, alu_lhs} - {1'b0, alu_rhs}; r = t[31:0]; end
      4'd2: r = alu_lhs << alu_rhs[4:0];
      4'd3: r = {31'd0, $signed(alu_lhs) < $signed(alu_rhs)};
      4'd4: r = {31'd0, alu_lhs < alu_rhs};
      4'd5: r = alu_lhs ^ alu_rhs;
      4'd6: r = alu_lhs >> alu_rhs[4:0];
      4'd7: r = $unsigned($signed(alu_lhs) >>> alu_rhs[4:0]);
      4'd8: r = alu_lhs | alu_rhs;
      4'd9: r = alu_lhs & alu_rhs;
      default: r = 32'd0;
    endcase
    alu_res   <= r;
    alu_flags <= {r == 32'd0, r[31], t[32], 1'b0};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request and check the two-posedge latency to out_valid.
  task automatic issue(input logic [1:0] k, input logic [2:0] f3, input logic b5,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin @(posedge clk); #1; n++; end
    if (n >= 10) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_kind = k; in_funct3 = f3; in_funct7b5 = b5; in_rs1 = a; in_rs2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_exec_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_hold_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = 2'b00; in_funct3 = 3'b000; in_funct7b5 = 1'b0;
    in_rs1 = 32'd0; in_rs2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res", out_res, 32'd0);
    check("rst_out_taken", 32'(out_taken), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_alu_lhs", alu_lhs, 32'd0);
    check("rst_alu_rhs", alu_rhs, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // R-type SUB 5-7
    issue(KIND_R, 3'b000, 1'b1, 32'd5, 32'd7);
    check("sub_res", out_res, 32'hFFFF_FFFE);
    check("sub_err", 32'(out_err), 32'd0);
    check("sub_taken", 32'(out_taken), 32'd0);
    check("sub_op", 32'(alu_op), 32'd1);
    accept();

    // BLTU / BLT with -1 vs 1
    issue(KIND_BR, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1);
    check("bltu_taken", 32'(out_taken), 32'd0);
    check("bltu_res", out_res, 32'd0);
    accept();
    issue(KIND_BR, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1);
    check("blt_taken", 32'(out_taken), 32'd1);
    check("blt_res", out_res, 32'd1);
    accept();

    // BEQ / BNE equal operands
    issue(KIND_BR, 3'b000, 1'b0, 32'h1234, 32'h1234);
    check("beq_taken", 32'(out_taken), 32'd1);
    check("beq_res", out_res, 32'd0);
    accept();
    issue(KIND_BR, 3'b001, 1'b0, 32'h1234, 32'h1234);
    check("bne_taken", 32'(out_taken), 32'd0);
    check("bne_err", 32'(out_err), 32'd0);
    accept();

    // SRAI with shift amount masking
    issue(KIND_I, 3'b101, 1'b1, 32'h8000_0000, 32'h24);
    check("srai_rhs", alu_rhs, 32'd4);
    check("srai_res", out_res, 32'hF800_0000);
    check("srai_op", 32'(alu_op), 32'd7);
    accept();

    // Illegal R-type 001/b5 and branch 010: op must stay SRA
    issue(KIND_R, 3'b001, 1'b1, 32'd3, 32'd1);
    check("rerr_err", 32'(out_err), 32'd1);
    check("rerr_res", out_res, 32'd0);
    check("rerr_taken", 32'(out_taken), 32'd0);
    check("rerr_op", 32'(alu_op), 32'd7);
    accept();
    issue(KIND_BR, 3'b010, 1'b0, 32'd9, 32'd9);
    check("brerr_err", 32'(out_err), 32'd1);
    check("brerr_taken", 32'(out_taken), 32'd0);
    check("brerr_op", 32'(alu_op), 32'd7);
    accept();
    issue(KIND_RSV, 3'b000, 1'b0, 32'd1, 32'd1);
    check("rsv_err", 32'(out_err), 32'd1);
    accept();

    // R-type SLL with masking, 1 << (0x21 & 31)
    issue(KIND_R, 3'b001, 1'b0, 32'd1, 32'h21);
    check("sll_rhs", alu_rhs, 32'd1);
    check("sll_res", out_res, 32'd2);
    accept();

    // ADDI with b5 set is still ADD; then backpressure with a stray request
    issue(KIND_I, 3'b000, 1'b1, 32'd3, 32'd4);
    in_valid = 1'b1; in_rs1 = 32'hDEAD; in_rs2 = 32'hBEEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_res", out_res, 32'd7);
      check("bp_err", 32'(out_err), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_lhs", alu_lhs, 32'd3);
    end
    in_valid = 1'b0;
    accept();

    // Reset while in HOLD
    issue(KIND_R, 3'b000, 1'b0, 32'h10, 32'h20);
    check("pre_rst_res", out_res, 32'h30);
    #3 rst_n = 1'b0;
    #1;
    check("hold_rst_valid", 32'(out_valid), 32'd0);
    check("hold_rst_res", out_res, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("hold_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_rst_no_valid", 32'(out_valid), 32'd0);

    // Reset while in EXEC
    in_kind = KIND_R; in_funct3 = 3'b000; in_funct7b5 = 1'b0;
    in_rs1 = 32'h55; in_rs2 = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("exec_lhs", alu_lhs, 32'h55);
    rst_n = 1'b0;
    #1;
    check("exec_rst_lhs", alu_lhs, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("exec_rst_no_valid", 32'(out_valid), 32'd0);
    check("exec_rst_in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Initiator side of the ALU operand/op/result interface. Accepts one decoded integer or branch request per transaction through a valid/ready handshake and translates funct3/funct7 into an ALU op code. It drives the ALU operand and op ports, captures the ALU result and flags after the ALU's negedge evaluation, and resolves branch conditions. It returns result, branch-taken and error on a backpressured output handshake, and sits between the instruction decoder and the ALU in the execute stage.

## Interface
- SHAMT_MASK, 1, when 1 the block drives alu_rhs[31:5]=0 for SLL/SRL/SRA ops; when 0, rhs is passed unmodified.
- clk  in  1  system clock; all block state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_kind  in  2  00 R-type, 01 I-type, 10 branch, 11 reserved (error).
- in_funct3  in  3  instruction funct3.
- in_funct7b5  in  1  instruction bit 30.
- in_rs1  in  32  operand 1.
- in_rs2  in  32  operand 2 (immediate already muxed for I-type).
- alu_lhs, alu_rhs  out  32  ALU operands, registered.
- alu_op  out  4  ALU op code, registered, from the shared ALU op defines.
- alu_res  in  32  ALU result.
- alu_flags  in  4  ALU flags: [3] zero, [2] sign (res[31]), [1] unsigned carry, [0] signed overflow.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_res  out  32  captured result.
- out_taken  out  1  branch taken (0 for non-branch).
- out_err  out  1  illegal kind/funct combination.

## Operation
- FSM states are IDLE, EXEC and HOLD.
- **IDLE:** in_ready=1. On in_valid, register the operands and the decoded op, then go to EXEC.
- **EXEC:** ALU inputs are stable. The ALU evaluates on the negedge inside this cycle. On the next posedge, capture the result and flags, compute out_res/out_taken/out_err, and go to HOLD.
- **HOLD:** out_valid=1 and outputs are frozen. When out_ready=1, go to IDLE. An accept and a new request are never taken in the same cycle.
- **R-type decode:**
  - 000 gives ADD, or SUB when b5=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101 gives SRL, or SRA when b5=1.
  - 110 OR, 111 AND.
  - b5=1 with any other funct3 sets out_err.
- **I-type decode:** same table, except 000 is always ADD (b5 ignored). b5=1 with 001 sets out_err.
- **Branch decode:**
  - BEQ 000: SUB, taken=flags[3].
  - BNE 001: SUB, taken=!flags[3].
  - BLT 100: SLT, taken=res[0].
  - BGE 101: SLT, taken=!res[0].
  - BLTU 110: SLTU, taken=res[0].
  - BGEU 111: SLTU, taken=!res[0].
  - 010 and 011 set out_err.
- **Error cases:** latency is unchanged and alu_op keeps its previous value. Outputs are out_res=0, out_taken=0, out_err=1.
- **Non-error branches:** out_res=alu_res.

## Timing
- **Reset values:** state IDLE, in_ready=1, out_valid=0, out_res=0, out_taken=0, out_err=0, alu_lhs=0, alu_rhs=0, alu_op=ADD.
- **Latency:** a request accepted at posedge N gives out_valid high after posedge N+1. With out_ready held high, in_ready returns after posedge N+2, so throughput is one request per 3 cycles.
- alu_lhs/rhs/op change only on IDLE→EXEC.
- alu_res/flags are sampled only on the EXEC→HOLD posedge.
- **Reset mid-operation** (EXEC or HOLD): outputs take their reset values immediately, the in-flight result is discarded, and no out_valid pulse follows.
- in_* are ignored outside IDLE.
- out_valid must not drop, and out_* must not change, while out_ready=0.

## Structure
- Op codes come from the existing shared ALU op define file.
- A new shared define file holds the in_kind codes (KIND_R/I/BR/RSV) and the 2-bit state encodings.
- Sub-module alu_issue_decode is purely combinational. It maps in_kind/in_funct3/in_funct7b5 to alu_op, a branch-sense code and err. The FSM and registers stay in alu_issue.

## Test plan
- **R-type SUB:** rs1=5, rs2=7, funct3=000, b5=1 → out_res=0xFFFFFFFE, out_err=0, out_valid after exactly 2 posedges.
- **BLTU / BLT, unsigned vs signed:** rs1=0xFFFFFFFF, rs2=1.
  - BLTU → out_taken=0.
  - BLT → out_taken=1.
- **BEQ / BNE:** rs1=rs2=0x1234.
  - BEQ → taken=1, out_res=0.
  - BNE → taken=0.
- **Shift masking:** SRAI with rs1=0x80000000, rs2=0x24, SHAMT_MASK=1 → alu_rhs=4, out_res=0xF8000000.
- **Errors:**
  - R-type funct3=001 with b5=1 → out_err=1, out_res=0, alu_op unchanged.
  - Branch funct3=010 → out_err=1.
- **Backpressure and reset:**
  - out_ready=0 for 5 cycles → out_* stable and in_ready=0.
  - rst_n low in HOLD → out_valid=0 at once and in_ready=1 after release.
